tap_delay_ctrl: RTL
===================

# tap_delay_ctrl

Programmable-latency delay line with a reconfiguration controller. Accepts a WIDTH-bit sample stream and re-emits each sample exactly `d` cycles later, where `d` is runtime-selectable. A change to `d` is sequenced so that no in-flight sample is lost, duplicated or reordered. It sits between capture front-ends and timestamp/alignment logic, wherever the fixed-depth shift-register utility is too rigid.

## Interface
- `WIDTH`, 1: sample width in bits.
- `MAX_DELAY`, 16: maximum delay in cycles; must be at least 2.
- `DEFAULT_DELAY`, 4: delay after reset; must satisfy 1 ≤ `DEFAULT_DELAY` ≤ `MAX_DELAY`.
- `DW`, derived, `$clog2(MAX_DELAY+1)`: width of the delay fields.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  sample present.
- `in_data`  in  WIDTH  sample.
- `in_ready`  out  1  sample accepted when `in_valid & in_ready`.
- `out_valid`  out  1  delayed sample present; no backpressure.
- `out_data`  out  WIDTH  delayed sample; equals 0 when `out_valid` = 0.
- `cfg_valid`  in  1  new delay request.
- `cfg_delay`  in  DW  requested delay.
- `cfg_ready`  out  1  request accepted when `cfg_valid & cfg_ready`.
- `cfg_err`  out  1  one-cycle pulse: the request was rejected.
- `cur_delay`  out  DW  delay currently applied.
- `busy`  out  1  high while a reconfiguration is in progress.

## Operation
- Storage is `MAX_DELAY` stages of {valid, data}, shifting every cycle.
  - Stage 0 loads {`in_valid & in_ready`, `in_data`}.
  - The output is taken from stage `cur_delay-1`.
- FSM states:
  - **RUN**: `in_ready` = 1, `cfg_ready` = 1, `busy` = 0.
  - **DRAIN**: `in_ready` = 0, `cfg_ready` = 0, `busy` = 1. Stages keep shifting with valid = 0 inserted. A down-counter is loaded with `cur_delay`, and the FSM leaves DRAIN when the counter reaches 1.
  - **SWITCH**: one cycle. `cur_delay` is loaded from the latched request; `in_ready` = 0, `busy` = 1. Next state is RUN.
- A request is legal when 1 ≤ `cfg_delay` ≤ `MAX_DELAY`.
  - A legal request accepted in RUN moves the FSM to DRAIN.
  - An illegal request is consumed: `cfg_err` pulses in the next cycle, the FSM stays in RUN, and `cur_delay` is unchanged.
  - A request equal to `cur_delay` is still sequenced through DRAIN and SWITCH.
- Simultaneous sample and legal request in the same RUN cycle: both are accepted. That sample is emitted at the old delay before SWITCH.
- Stage data is not cleared on reconfiguration. Only the valid bits gate the output.
- Reset:
  - FSM goes to RUN and `cur_delay` = `DEFAULT_DELAY`.
  - All stage valid bits are cleared; `out_valid` = 0 and `out_data` = 0.
  - `in_ready` = 1, `cfg_ready` = 1, `cfg_err` = 0, `busy` = 0.
  - A reset during DRAIN or SWITCH discards the pending request and any in-flight samples.

## Timing
- Latency: a sample accepted in cycle n appears on `out_valid`/`out_data` in cycle n+d, with d = `cur_delay` ≥ 1.
- Full throughput in RUN: one sample per cycle.
- Reconfiguration, with a request accepted in cycle n and old delay d:
  - DRAIN occupies cycles n+1 … n+d.
  - SWITCH occupies cycle n+d+1.
  - RUN resumes in cycle n+d+2 with the new `cur_delay`; `in_ready` = 1 in that cycle.
  - The input is stalled for d+1 cycles.
- The last old-delay sample emits in cycle n+d, at the latest. No valid output occurs in cycles n+d+1 through n+d+2+newd-1 unless a sample is accepted in cycle n+d+2.
- `cfg_err` is registered and asserts exactly one cycle after the rejected handshake.

## Configuration
- Macro: `TAP_DELAY_DRAIN_EN`.
- Defined: reconfiguration uses DRAIN/SWITCH exactly as described above.
- Undefined:
  - There are no DRAIN or SWITCH states. `in_ready` and `cfg_ready` are tied to 1 and `busy` is tied to 0.
  - A legal request accepted in cycle n sets `cur_delay` in cycle n+1. The output tap moves immediately.
  - Samples older than the new delay are dropped. Samples younger than it emit early or late according to the new tap.
  - Illegal requests pulse `cfg_err` exactly as in the defined build.

## Test plan
- Reset, then stream 0x01..0x10 continuously with the default delay of 4 → `out_data` = 0x01 in the 4th cycle after the first accept, then contiguous, with no gaps.
- Stream, then request delay 9 in the same cycle as sample 0x2A (old delay 4) → 0x2A emits 4 cycles later; `in_ready` is low for 5 cycles; the next sample emits 9 cycles after its accept.
- Request `cfg_delay` = 0, and separately `MAX_DELAY`+1 → `cfg_err` pulses one cycle later each time; `cur_delay` is unchanged; `in_ready` never drops.
- Request delay 1 (from 4), then `MAX_DELAY` back-to-back once `cfg_ready` returns → each applies in order; latency of 1, then 16, is verified per sample.
- Assert `rst` in the 2nd DRAIN cycle → the next cycle is RUN with `cur_delay` = 4, `out_valid` = 0, and no stale samples emitted.
- Without `TAP_DELAY_DRAIN_EN`, switch delay 8→3 mid-stream → `cur_delay` = 3 on the next cycle; samples aged more than 3 never emit; `busy` stays 0.

Source files
------------

// File: rtl/tap_delay_ctrl.sv
// ============================================================================
// Module      : tap_delay_ctrl
// Description : Programmable-latency delay line. Each accepted sample is
//               re-emitted exactly cur_delay_o cycles after acceptance.
//               The delay can be changed at runtime through a cfg handshake.
//               Illegal requests (0 or > MAX_DELAY) are consumed and answered
//               with a one-cycle cfg_err_o pulse.
// Build option: TAP_DELAY_DRAIN_EN
//               defined   - a delay change stalls the input, drains the
//                           in-flight samples at the old delay (DRAIN), then
//                           applies the new delay (SWITCH) before resuming.
//               undefined - the output tap moves on the cycle after the
//                           request; in_ready_o/cfg_ready_o tied 1, busy_o 0.
// Ports       : clk, rst       clock, synchronous active-high reset
//               in_valid_i / in_data_i / in_ready_o     sample input
//               out_valid_o / out_data_o                delayed sample output
//               cfg_valid_i / cfg_delay_i / cfg_ready_o delay request
//               cfg_err_o     one-cycle pulse after a rejected request
//               cur_delay_o   delay currently applied
//               busy_o        reconfiguration in progress
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tap_delay_ctrl #(
    parameter int WIDTH         = 1,
    parameter int MAX_DELAY     = 16,
    parameter int DEFAULT_DELAY = 4,
    localparam int DW           = $clog2(MAX_DELAY + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    input  logic             cfg_valid_i,
    input  logic [DW-1:0]    cfg_delay_i,
    output logic             cfg_ready_o,
    output logic             cfg_err_o,
    output logic [DW-1:0]    cur_delay_o,
    output logic             busy_o
);

    localparam logic [DW-1:0] c_MAX_DELAY     = DW'(MAX_DELAY);
    localparam logic [DW-1:0] c_DEFAULT_DELAY = DW'(DEFAULT_DELAY);

    logic [MAX_DELAY-1:0] vld_q;
    logic [WIDTH-1:0]     dat_q [MAX_DELAY];
    logic [DW-1:0]        cur_delay_q;
    logic                 cfg_err_q;

    logic                 w_accept;
    logic                 w_cfg_fire;
    logic                 w_legal;
    logic                 w_clear;
    logic                 w_tap_vld;
    logic [WIDTH-1:0]     w_tap_dat;

    assign w_accept   = in_valid_i & in_ready_o;
    assign w_cfg_fire = cfg_valid_i & cfg_ready_o;
    assign w_legal    = (cfg_delay_i != '0) && (cfg_delay_i <= c_MAX_DELAY);

    // ------------------------------------------------------------------
    // Shift register. Data is never cleared; only valid bits gate output.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        dat_q[0] <= in_data_i;
        for (int i = 1; i < MAX_DELAY; i++) begin
            dat_q[i] <= dat_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else if (w_clear) begin
            vld_q <= '0;
        end else begin
            vld_q <= {vld_q[MAX_DELAY-2:0], w_accept};
        end
    end

    // Output tap: stage cur_delay-1. Written as a compare mux so the select
    // width need not match the array depth.
    always_comb begin
        w_tap_vld = 1'b0;
        w_tap_dat = '0;
        for (int i = 0; i < MAX_DELAY; i++) begin
            if (cur_delay_q == DW'(i + 1)) begin
                w_tap_vld = vld_q[i];
                w_tap_dat = dat_q[i];
            end
        end
    end

    assign out_valid_o = w_tap_vld;
    assign out_data_o  = w_tap_vld ? w_tap_dat : '0;
    assign cur_delay_o = cur_delay_q;
    assign cfg_err_o   = cfg_err_q;

`ifdef TAP_DELAY_DRAIN_EN
    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_SWITCH = 2'd2
    } state_t;

    state_t        state_q;
    logic [DW-1:0] req_q;
    logic [DW-1:0] cnt_q;
    logic          in_ready_q;
    logic          cfg_ready_q;
    logic          busy_q;

    // Clearing every valid bit at SWITCH is what prevents a longer new delay
    // from re-emitting samples that already left through the old tap.
    assign w_clear     = (state_q == S_SWITCH);
    assign in_ready_o  = in_ready_q;
    assign cfg_ready_o = cfg_ready_q;
    assign busy_o      = busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RUN;
            cur_delay_q <= c_DEFAULT_DELAY;
            req_q       <= c_DEFAULT_DELAY;
            cnt_q       <= '0;
            cfg_err_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            cfg_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            cfg_err_q <= w_cfg_fire & ~w_legal;
            case (state_q)
                S_RUN: begin
                    if (w_cfg_fire && w_legal) begin
                        req_q       <= cfg_delay_i;
                        cnt_q       <= cur_delay_q;
                        state_q     <= S_DRAIN;
                        in_ready_q  <= 1'b0;
                        cfg_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    // Counter starts at the old delay: DRAIN lasts d cycles,
                    // long enough for the newest sample to reach the tap.
                    if (cnt_q <= DW'(1)) begin
                        state_q <= S_SWITCH;
                    end else begin
                        cnt_q <= cnt_q - DW'(1);
                    end
                end
                S_SWITCH: begin
                    cur_delay_q <= req_q;
                    state_q     <= S_RUN;
                    in_ready_q  <= 1'b1;
                    cfg_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
                default: begin
                    state_q     <= S_RUN;
                    in_ready_q  <= 1'b1;
                    cfg_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end
`else
    assign w_clear     = 1'b0;
    assign in_ready_o  = 1'b1;
    assign cfg_ready_o = 1'b1;
    assign busy_o      = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_delay_q <= c_DEFAULT_DELAY;
            cfg_err_q   <= 1'b0;
        end else begin
            cfg_err_q <= w_cfg_fire & ~w_legal;
            if (w_cfg_fire && w_legal) begin
                cur_delay_q <= cfg_delay_i;
            end
        end
    end
`endif

endmodule

`default_nettype wire
